mine_game_ctrl: RTL and testbench
=================================

# mine_game_ctrl

Sequencing controller for the 8×16 mine-matrix game datapath. It collects 4×4 keypad hits into a 16-bit dot mask for the selected 4×4 area, issues a single-cycle commit pulse (`switch`) to the matrix block, and evaluates that block's `result` hit flag. It also counts successful turns, runs the round timer, and drives `finish` so the matrix freezes at game end. It sits between the keypad/button front-end and the matrix block.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per timer tick (1 s at 50 MHz).
- `TIME_LIMIT`, default 60: timer ticks per game.
- `MAX_TURNS`, default 8: successful commits required to win.
- `clock`, input, 1: clock.
- `reset`, input, 1: synchronous, active-low.
- `key_valid`, input, 1: one-cycle pulse; `key_code` is valid.
- `key_code`, input, 4: keypad cell index 0..15, row-major.
- `area_btn`, input, 1: one-cycle pulse; advance area.
- `confirm_btn`, input, 1: one-cycle pulse; start game or commit.
- `result`, input, 1: mine-hit flag from the matrix block.
- `area`, output, 3: selected area to the matrix block.
- `dot`, output, 16: pending press mask.
- `switch`, output, 1: one-cycle commit strobe.
- `finish`, output, 1: game over; held high.
- `win`, output, 1: game won; held high.
- `lose`, output, 1: game lost; held high.
- `turns`, output, 4: successful commits so far.
- `time_left`, output, 8: remaining timer ticks.

## Operation
- **Reset values.** The following apply at reset and whenever `reset`=0 at a rising edge, including mid-game:
  - `area`=0, `dot`=0, `switch`=0, `finish`=0, `win`=0, `lose`=0, `turns`=0, `time_left`=`TIME_LIMIT`.
  - State returns to IDLE and the tick prescaler clears.
- **States:** IDLE, SELECT, COMMIT, CHECK, WIN, LOSE.
- **IDLE.** `confirm_btn` moves to SELECT and reloads the timer. All other inputs are ignored.
- **SELECT.** Input priority per cycle is `confirm_btn` > `area_btn` > `key_valid`. A lower-priority pulse arriving in the same cycle is dropped.
  - `key_valid` toggles `dot[15-key_code]`. Key 0 maps to bit 15, matching the matrix block's MSB-first area fill.
  - `area_btn` sets `area`←`area`+1 mod 8 (7 wraps to 0) and clears `dot`.
  - `confirm_btn` with `dot`≠0 moves to COMMIT. With `dot`=0 it is ignored.
- **COMMIT.** `switch`=1 for exactly this cycle; `area` and `dot` are held stable. Next state is CHECK.
- **CHECK.** `result` is sampled; the matrix block registers it on the edge that sampled `switch`.
  - `result`=1: go to LOSE.
  - `result`=0: `turns`+1. If the new value equals `MAX_TURNS`, go to WIN; otherwise clear `dot` and return to SELECT with `area` unchanged.
- **WIN / LOSE.** `finish`=1 and `win`=1 (or `lose`=1). Terminal until reset; all inputs are ignored.
- **Timer.** The timer decrements only in SELECT, once per tick.
  - When `time_left` reaches 0, the next cycle enters LOSE.
  - Timeout beats a `confirm_btn` arriving in the same cycle.
  - The prescaler is held while in COMMIT and CHECK, and keeps its count (no clear).
- **Width rules.** `turns` saturates at `MAX_TURNS`. `time_left` never underflows below 0.

## Timing
- `key_valid` → `dot` update: 1 cycle (registered).
- `confirm_btn` in SELECT → `switch` high: next cycle.
- `switch` high → CHECK evaluation: next cycle.
- Commit round trip, SELECT → SELECT: 3 cycles.
- WIN/LOSE outputs are registered and go high on the cycle the state is entered.
- A `result` rising outside CHECK is ignored until the next CHECK.

## Configuration
- Macro: `MINE_GAME_TIMER_EN`.
- **Defined:** the prescaler and `time_left` countdown are built, and timeout leads to LOSE.
- **Undefined:** the prescaler logic is removed and `time_left` is a constant `TIME_LIMIT`; the game ends only by hit or win.

## Structure
- Shared package `mine_pkg` holds:
  - the state enum;
  - `NUM_AREAS`=8, `AREA_W`=3, `DOT_W`=16, `ROWS`=8, `COLS`=16.
- One sub-module, `mine_tick_gen`, provides the parameterised prescaler with enable and synchronous active-low clear. It emits a one-cycle `tick`.
- Everything else lives in a single FSM module.

## Test plan
- **Area wrap and dot clearing:** Reset, `confirm_btn`, 9× `area_btn`, `key_code`=3 → `area`=1 and `dot`=16'h1000.
- **Toggle and empty confirm:** `key_code`=5 pressed twice, then `confirm_btn` → `dot`=0, no `switch` pulse, state stays SELECT.
- **Safe turns to a win:** 8 commits with `result`=0 (`MAX_TURNS`=8) → `switch` pulses exactly once per commit, each 1 cycle; `turns`=8; `win`=1, `finish`=1.
- **Hit:** Commit with `result`=1 in CHECK → `lose`=1 and `finish`=1 next cycle; further `confirm_btn` gives no `switch`.
- **Timeout:** `TICK_DIV`=4, `TIME_LIMIT`=3, idle in SELECT → `lose`=1 after 12 cycles. The same run with `confirm_btn` on the timeout cycle also gives LOSE.
- **Reset mid-commit:** `reset`=0 in COMMIT → next cycle all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/mine_pkg.sv
// mine_pkg: shared state type, matrix geometry and keypad mapping for the mine game
package mine_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_COMMIT, S_CHECK, S_WIN, S_LOSE} state_t;
  localparam int NUM_AREAS = 8;
  localparam int AREA_W = 3;
  localparam int DOT_W = 16;
  localparam int ROWS = 8;
  localparam int COLS = 16;
  // key 0 lands on the MSB so the mask lines up with the matrix block's MSB-first area fill
  function automatic logic [DOT_W-1:0] key_bit(input logic [3:0] code);
    return DOT_W'(1) << (4'd15 - code);
  endfunction
endpackage

// File: rtl/mine_tick_gen.sv
// mine_tick_gen: enable-gated prescaler emitting a one-cycle tick every DIV enabled cycles
module mine_tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(DIV - 1);
  // counts only while enabled; dropping en freezes the count where it is
  always_ff @(posedge clock) begin
    if (!reset) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/mine_game_ctrl.sv
// mine_game_ctrl: keypad/area sequencing, commit strobe, hit evaluation and round timer (MINE_GAME_TIMER_EN builds the countdown)
module mine_game_ctrl
  import mine_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_LIMIT = 60,
  parameter int MAX_TURNS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              area_btn,
  input  logic              confirm_btn,
  input  logic              result,
  output logic [AREA_W-1:0] area,
  output logic [DOT_W-1:0]  dot,
  output logic              switch,
  output logic              finish,
  output logic              win,
  output logic              lose,
  output logic [3:0]        turns,
  output logic [7:0]        time_left
);
  state_t state;
  logic timeout;
  logic [3:0] turns_nxt;
  assign turns_nxt = (turns == 4'(MAX_TURNS)) ? turns : turns + 4'd1;
`ifdef MINE_GAME_TIMER_EN
  logic tick;
  mine_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .en(state == S_SELECT),
    .tick(tick)
  );
  assign timeout = time_left == 8'd0 || (tick && time_left == 8'd1);
  // countdown: reload on game start, one step per tick while selecting, floor at zero
  always_ff @(posedge clock) begin
    if (!reset) time_left <= 8'(TIME_LIMIT);
    else if (state == S_IDLE && confirm_btn) time_left <= 8'(TIME_LIMIT);
    else if (state == S_SELECT && tick && time_left != 8'd0) time_left <= time_left - 8'd1;
  end
`else
  assign timeout = 1'b0;
  assign time_left = 8'(TIME_LIMIT);
`endif
  // sequencing: area/dot editing, commit strobe, hit evaluation and terminal flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      area <= '0;
      dot <= '0;
      switch <= 1'b0;
      finish <= 1'b0;
      win <= 1'b0;
      lose <= 1'b0;
      turns <= '0;
    end else begin
      switch <= 1'b0;
      case (state)
        S_IDLE: if (confirm_btn) state <= S_SELECT;
        S_SELECT:
          if (timeout) begin
            state <= S_LOSE;
            finish <= 1'b1;
            lose <= 1'b1;
          end else if (confirm_btn) begin
            if (dot != '0) begin
              state <= S_COMMIT;
              switch <= 1'b1;
            end
          end else if (area_btn) begin
            area <= (area == AREA_W'(NUM_AREAS - 1)) ? '0 : area + 1'b1;
            dot <= '0;
          end else if (key_valid) dot <= dot ^ key_bit(key_code);
        S_COMMIT: state <= S_CHECK;
        S_CHECK:
          if (result) begin
            state <= S_LOSE;
            finish <= 1'b1;
            lose <= 1'b1;
          end else begin
            turns <= turns_nxt;
            if (turns_nxt == 4'(MAX_TURNS)) begin
              state <= S_WIN;
              finish <= 1'b1;
              win <= 1'b1;
            end else begin
              dot <= '0;
              state <= S_SELECT;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mine_game_ctrl.sv
// tb_mine_game_ctrl: randomized and directed stimulus checked against a game-rule model through commit/end scoreboards
module tb_mine_game_ctrl;
`ifdef MINE_GAME_TIMER_EN
  localparam int TD = 4;
  localparam int TL = 3;
`else
  localparam int TD = 50_000_000;
  localparam int TL = 60;
`endif
  localparam int MT = 8;
  localparam int P_IDLE = 0, P_SEL = 1, P_COM = 2, P_CHK = 3, P_WIN = 4, P_LOSE = 5;

  logic clock = 1'b1;
  logic reset = 1'b0;
  logic key_valid = 1'b0, area_btn = 1'b0, confirm_btn = 1'b0, result = 1'b0;
  logic [3:0] key_code = '0;
  logic [2:0] area;
  logic [15:0] dot;
  logic switch, finish, win, lose;
  logic [3:0] turns;
  logic [7:0] time_left;

  int checks = 0, errors = 0, sw_cnt = 0;
  int ph = P_IDLE, m_area = 0, m_turns = 0, m_sel = 0;
  logic [15:0] m_dot = '0;
  logic [18:0] com_q[$];
  logic [5:0] end_q[$];
  logic fin_d = 1'b0;

  mine_game_ctrl #(.TICK_DIV(TD), .TIME_LIMIT(TL), .MAX_TURNS(MT)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .area_btn(area_btn), .confirm_btn(confirm_btn), .result(result),
    .area(area), .dot(dot), .switch(switch), .finish(finish), .win(win),
    .lose(lose), .turns(turns), .time_left(time_left)
  );

  always #5 clock = ~clock;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // remaining time after s cycles spent selecting: one tick per TD cycles, never below zero
  function automatic int tl_at(int s);
`ifdef MINE_GAME_TIMER_EN
    return (TL - s / TD) > 0 ? TL - s / TD : 0;
`else
    return TL + 0 * s;
`endif
  endfunction

  function automatic void go_end(bit w);
    ph = w ? P_WIN : P_LOSE;
    end_q.push_back({w, !w, 4'(m_turns)});
  endfunction

  // game rules applied to one cycle of inputs; leaves the model at the state after the coming edge
  function automatic void model_step(logic r, logic kv, logic [3:0] kc, logic ab, logic cb, logic res);
    int idx;
    if (!r) begin
      ph = P_IDLE; m_area = 0; m_dot = '0; m_turns = 0; m_sel = 0;
      com_q.delete(); end_q.delete();
      return;
    end
    case (ph)
      P_IDLE: if (cb) begin ph = P_SEL; m_sel = 0; end
      P_SEL: begin
        if (tl_at(m_sel + 1) == 0) go_end(0);
        else if (cb) begin
          if (m_dot != 0) begin ph = P_COM; com_q.push_back({3'(m_area), m_dot}); end
        end else if (ab) begin
          m_area = (m_area + 1) % 8; m_dot = '0;
        end else if (kv) begin
          idx = 15 - int'(kc);
          m_dot[idx] = ~m_dot[idx];
        end
        m_sel++;
      end
      P_COM: ph = P_CHK;
      P_CHK:
        if (res) go_end(0);
        else begin
          m_turns++;
          if (m_turns == MT) go_end(1);
          else begin m_dot = '0; ph = P_SEL; end
        end
      default: ;
    endcase
  endfunction

  // monitor: per-cycle state comparison plus commit and game-end scoreboards
  always @(posedge clock) begin
    logic [18:0] ce;
    logic [5:0] ee;
    #1;
    chk("area", 32'(area), 32'(m_area));
    chk("dot", 32'(dot), 32'(m_dot));
    chk("turns", 32'(turns), 32'(m_turns));
    chk("time_left", 32'(time_left), 32'(tl_at(m_sel)));
    chk("switch", 32'(switch), 32'(ph == P_COM));
    chk("finish", 32'(finish), 32'(ph == P_WIN || ph == P_LOSE));
    chk("win", 32'(win), 32'(ph == P_WIN));
    chk("lose", 32'(lose), 32'(ph == P_LOSE));
    if (switch === 1'b1) begin
      sw_cnt++;
      checks++;
      if (com_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: switch=1 with no commit expected");
      end else begin
        ce = com_q.pop_front();
        chk("commit_area", 32'(area), 32'(ce[18:16]));
        chk("commit_dot", 32'(dot), 32'(ce[15:0]));
      end
    end
    if (finish === 1'b1 && !fin_d) begin
      checks++;
      if (end_q.size() == 0) begin
        errors++;
        $display("FAIL end_unexpected: finish=1 with no game end expected");
      end else begin
        ee = end_q.pop_front();
        chk("end_flags", 32'({win, lose, turns}), 32'(ee));
      end
    end
    fin_d = finish;
  end

  task automatic cyc(input logic r, input logic kv, input logic [3:0] kc, input logic ab, input logic cb, input logic res);
    @(negedge clock);
    reset = r; key_valid = kv; key_code = kc; area_btn = ab; confirm_btn = cb; result = res;
    model_step(r, kv, kc, ab, cb, res);
  endtask

  task automatic idle(); cyc(1, 0, 0, 0, 0, 1'($urandom_range(0, 1))); endtask
  task automatic do_reset(); cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic conf(); cyc(1, 0, 0, 0, 1, 0); endtask
  task automatic abtn(); cyc(1, 0, 0, 1, 0, 0); endtask
  task automatic key(input int k); cyc(1, 1, 4'(k), 0, 0, 0); endtask
  task automatic commit(input logic res);
    conf();
    cyc(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    cyc(1, 0, 0, 0, 0, res);
  endtask
  task automatic settle(); @(posedge clock); #2; endtask

  initial begin
    int s0, n;
    do_reset(); settle();
    chk("rst_area", 32'(area), 0);
    chk("rst_dot", 32'(dot), 0);
    chk("rst_flags", 32'({switch, finish, win, lose}), 0);
    chk("rst_turns", 32'(turns), 0);
    chk("rst_time", 32'(time_left), TL);

    conf();
    repeat (9) abtn();
    key(3); settle();
    chk("wrap_area", 32'(area), 1);
    chk("wrap_dot", 32'(dot), 32'h1000);

    do_reset(); conf(); key(5); key(5);
    s0 = sw_cnt; conf(); settle();
    chk("toggle_dot", 32'(dot), 0);
    chk("empty_confirm_switch", 32'(sw_cnt - s0), 0);
    key(0); settle();
    chk("still_select", 32'(dot), 32'h8000);

`ifndef MINE_GAME_TIMER_EN
    do_reset(); conf(); s0 = sw_cnt;
    for (int i = 0; i < 8; i++) begin key(i); commit(0); end
    settle();
    chk("win_turns", 32'(turns), 8);
    chk("win_flags", 32'({finish, win, lose}), 32'b110);
    chk("win_switches", 32'(sw_cnt - s0), 8);
    conf(); idle(); settle();
    chk("win_frozen", 32'(sw_cnt - s0), 8);
`endif

    do_reset(); conf(); key(1); s0 = sw_cnt;
    commit(1); settle();
    chk("hit_flags", 32'({finish, win, lose}), 32'b101);
    chk("hit_turns", 32'(turns), 0);
    key(2); conf(); idle(); settle();
    chk("hit_frozen", 32'(sw_cnt - s0), 1);

`ifdef MINE_GAME_TIMER_EN
    do_reset(); conf(); n = 0;
    while (lose !== 1'b1 && n < 40) begin idle(); settle(); n++; end
    chk("timeout_cycles", 32'(n), 12);
    do_reset(); conf(); key(2);
    repeat (10) idle();
    s0 = sw_cnt; conf(); settle();
    chk("timeout_beats_confirm", 32'(lose), 1);
    idle(); settle();
    chk("timeout_no_switch", 32'(sw_cnt - s0), 0);
`endif

    do_reset(); conf(); key(4); conf();
    cyc(0, 0, 0, 0, 0, 0); settle();
    chk("midrst_area", 32'(area), 0);
    chk("midrst_dot", 32'(dot), 0);
    chk("midrst_flags", 32'({switch, finish, win, lose}), 0);
    chk("midrst_time", 32'(time_left), TL);
    key(3); settle();
    chk("midrst_idle", 32'(dot), 0);
    conf(); key(3); settle();
    chk("midrst_restart", 32'(dot), 32'h1000);

    for (int g = 0; g < 24; g++) begin
      do_reset(); conf();
      for (int c = 0; c < 150; c++)
        cyc($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
            (g % 2 == 1) && $urandom_range(0, 5) == 0);
    end

    idle(); settle();
    chk("queues_drained", 32'(com_q.size() + end_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
